// File: rtl/mem_mover_pkg.sv
// Shared types and default widths for the data-RAM block mover.
package mem_mover_pkg;

  localparam int unsigned MM_ADDR_W = 8;
  localparam int unsigned MM_DATA_W = 8;
  localparam int unsigned MM_LEN_W  = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } mover_state_t;

  typedef enum logic {
    OP_COPY = 1'b0,
    OP_FILL = 1'b1
  } mover_op_t;

endpackage

// File: rtl/mem_block_mover_if.sv
// Data-RAM port bundle: the mover is the master, data_ram the slave.
interface mem_block_mover_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic              MemRead;
  logic              MemWrite;
  logic [ADDR_W-1:0] mem_index;
  logic [DATA_W-1:0] write_value;
  logic [DATA_W-1:0] read_value;

  modport master (
    output MemRead,
    output MemWrite,
    output mem_index,
    output write_value,
    input  read_value
  );

  modport slave (
    input  MemRead,
    input  MemWrite,
    input  mem_index,
    input  write_value,
    output read_value
  );
endinterface

// File: rtl/mem_block_mover.sv
// Copy/fill engine for data_ram: owns the RAM port while busy, one byte per RD/WR pair.
module mem_block_mover
  import mem_mover_pkg::*;
#(
  parameter int unsigned ADDR_W = MM_ADDR_W,
  parameter int unsigned DATA_W = MM_DATA_W,
  parameter int unsigned LEN_W  = MM_LEN_W
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  start,
  input  logic                  op,
  input  logic [ADDR_W-1:0]     src_addr,
  input  logic [ADDR_W-1:0]     dst_addr,
  input  logic [LEN_W-1:0]      length,
  input  logic [DATA_W-1:0]     fill_value,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_W-1:0]      bytes_done,
  mem_block_mover_if.master     mem_port
);

  mover_state_t      state_q, state_d;
  mover_op_t         op_q;
  logic [ADDR_W-1:0] src_cur, dst_cur;
  logic [LEN_W-1:0]  remaining, bytes_q;
  logic [DATA_W-1:0] data_q, fill_q;

  logic              mem_read, mem_write;
  logic [ADDR_W-1:0] mem_index;
  logic [DATA_W-1:0] write_value;

  // State register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (length == '0)                      state_d = DONE;
          else if (mover_op_t'(op) == OP_COPY)   state_d = RD;
          else                                   state_d = WR;
        end
      end
      RD:   state_d = WR;
      WR: begin
        if (remaining == LEN_W'(1))  state_d = DONE;
        else if (op_q == OP_COPY)    state_d = RD;
        else                         state_d = WR;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch, address/length counters and the read-data holding register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      op_q      <= OP_COPY;
      src_cur   <= '0;
      dst_cur   <= '0;
      remaining <= '0;
      bytes_q   <= '0;
      data_q    <= '0;
      fill_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            op_q      <= mover_op_t'(op);
            src_cur   <= src_addr;
            dst_cur   <= dst_addr;
            remaining <= length;
            fill_q    <= fill_value;
            bytes_q   <= '0;
          end
        end
        RD: data_q <= mem_port.read_value;
        WR: begin
          src_cur   <= src_cur + ADDR_W'(1);
          dst_cur   <= dst_cur + ADDR_W'(1);
          remaining <= remaining - LEN_W'(1);
          bytes_q   <= bytes_q + LEN_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Moore output decode: address/data only leave zero while a strobe is up
  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_index   = '0;
    write_value = '0;
    unique case (state_q)
      RD: begin
        mem_read  = 1'b1;
        mem_index = src_cur;
      end
      WR: begin
        mem_write   = 1'b1;
        mem_index   = dst_cur;
        write_value = (op_q == OP_COPY) ? data_q : fill_q;
      end
      default: ;
    endcase
  end

  assign busy                 = (state_q != IDLE);
  assign done                 = (state_q == DONE);
  assign bytes_done           = bytes_q;
  assign mem_port.MemRead     = mem_read;
  assign mem_port.MemWrite    = mem_write;
  assign mem_port.mem_index   = mem_index;
  assign mem_port.write_value = write_value;

endmodule

// File: tb/tb_mem_block_mover.sv
// Bench for mem_block_mover: data_ram model, transaction-level reference, per-cycle monitor.
module tb_mem_block_mover;
  import mem_mover_pkg::*;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       start = 1'b0;
  logic       op = 1'b0;
  logic [7:0] src_addr = '0;
  logic [7:0] dst_addr = '0;
  logic [8:0] length = '0;
  logic [7:0] fill_value = '0;
  logic       busy, done;
  logic [8:0] bytes_done;

  mem_block_mover_if #(.ADDR_W(8), .DATA_W(8)) mif ();

  mem_block_mover #(.ADDR_W(8), .DATA_W(8), .LEN_W(9)) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .start      (start),
    .op         (op),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .length     (length),
    .fill_value (fill_value),
    .busy       (busy),
    .done       (done),
    .bytes_done (bytes_done),
    .mem_port   (mif.master)
  );

  always #5 CLK = ~CLK;

  // data_ram: combinational read, write on posedge; bench preload port has priority
  logic [7:0] ram [256];
  logic       pl_we = 1'b0;
  logic [7:0] pl_addr = '0, pl_data = '0;
  assign mif.read_value = ram[mif.mem_index];
  always @(posedge CLK) begin
    if (pl_we)             ram[pl_addr] <= pl_data;
    else if (mif.MemWrite) ram[mif.mem_index] <= mif.write_value;
  end

  // Reference: expected memory image and expected strobe sequence of the current request
  typedef struct packed {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
  } txn_t;
  logic [7:0] exp_ram [256];
  txn_t       exp_q[$];
  int         req_id = 0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Per-cycle monitor
  int   mon_req = 0;
  int   mon_idx = 0;
  logic done_prev = 1'b0;
  always @(negedge CLK) begin
    if (mon_req != req_id) begin
      mon_req = req_id;
      mon_idx = 0;
    end
    if (RESET_N) begin
      if (mif.MemRead || mif.MemWrite) begin
        check("strobe_exclusive", {31'd0, mif.MemRead && mif.MemWrite}, 32'd0);
        if (mon_idx >= exp_q.size()) begin
          check("unexpected_strobe", {mif.MemRead, mif.MemWrite, mif.mem_index}, 32'hFFFF_FFFF);
        end else begin
          check("strobe_kind", {31'd0, mif.MemWrite}, {31'd0, exp_q[mon_idx].wr});
          check("strobe_addr", {24'd0, mif.mem_index}, {24'd0, exp_q[mon_idx].addr});
          if (exp_q[mon_idx].wr)
            check("write_data", {24'd0, mif.write_value}, {24'd0, exp_q[mon_idx].data});
          check("busy_during_strobe", {31'd0, busy}, 32'd1);
          mon_idx++;
        end
      end else if (!busy || done) begin
        check("idle_bus_zero", {16'd0, mif.mem_index, mif.write_value}, 32'd0);
      end
      if (done && done_prev) check("done_single_cycle", 32'd1, 32'd0);
      done_prev = done;
    end else begin
      done_prev = 1'b0;
    end
  end

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    @(posedge CLK); #2;
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(posedge CLK); #1;
    pl_we = 1'b0;
    exp_ram[a] = d;
  endtask

  // Forward byte-by-byte semantics: each write is visible to later reads of the same request
  task automatic build_model(input logic o, input logic [7:0] s, input logic [7:0] d,
                             input int unsigned n, input logic [7:0] f);
    logic [7:0] as, ad, v;
    exp_q.delete();
    for (int unsigned i = 0; i < n; i++) begin
      as = s + 8'(i);
      ad = d + 8'(i);
      if (o == 1'b0) begin
        v = exp_ram[as];
        exp_q.push_back('{wr: 1'b0, addr: as, data: v});
      end else begin
        v = f;
      end
      exp_q.push_back('{wr: 1'b1, addr: ad, data: v});
      exp_ram[ad] = v;
    end
    req_id++;
  endtask

  task automatic pulse_start(input logic o, input logic [7:0] s, input logic [7:0] d,
                             input int unsigned n, input logic [7:0] f);
    @(posedge CLK); #2;
    start = 1'b1; op = o; src_addr = s; dst_addr = d; length = 9'(n); fill_value = f;
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  task automatic run_req(input string tag, input logic o, input logic [7:0] s,
                         input logic [7:0] d, input int unsigned n, input logic [7:0] f);
    int edges;
    int diffs;
    int unsigned lat;
    build_model(o, s, d, n, f);
    pulse_start(o, s, d, n, f);
    edges = 0;
    while (!done && edges < 700) begin
      @(posedge CLK); #1;
      edges++;
    end
    lat = (n == 0) ? 0 : ((o == 1'b0) ? 2 * n : n);
    check({tag, "_latency"}, 32'(edges), 32'(lat));
    check({tag, "_done_busy"}, {30'd0, done, busy}, 32'd3);
    check({tag, "_bytes_done"}, {23'd0, bytes_done}, 32'(n));
    check({tag, "_strobe_count"}, 32'(mon_idx), 32'(exp_q.size()));
    @(posedge CLK); #1;
    check({tag, "_after_done"}, {30'd0, done, busy}, 32'd0);
    check({tag, "_bytes_hold"}, {23'd0, bytes_done}, 32'(n));
    diffs = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== exp_ram[i]) diffs++;
    check({tag, "_ram_image_diffs"}, 32'(diffs), 32'd0);
  endtask

  initial begin
    logic [7:0] pin [4];
    int         lim;

    #1;
    check("reset_outputs",
          {busy, done, bytes_done, mif.MemRead, mif.MemWrite, mif.mem_index, mif.write_value},
          32'd0);
    for (int i = 0; i < 256; i++) preload(8'(i), 8'(i) ^ 8'h5C);
    @(posedge CLK); #2;
    RESET_N = 1'b1;

    // 1: plain copy
    preload(8'h10, 8'hA1); preload(8'h11, 8'hB2); preload(8'h12, 8'hC3); preload(8'h13, 8'hD4);
    run_req("copy4", 1'b0, 8'h10, 8'h40, 4, 8'h00);
    pin = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    for (int i = 0; i < 4; i++) check("copy4_pin", {24'd0, ram[8'h40 + 8'(i)]}, {24'd0, pin[i]});

    // 2: fill
    run_req("fill3", 1'b1, 8'h00, 8'h80, 3, 8'h5A);
    for (int i = 0; i < 3; i++) check("fill3_pin", {24'd0, ram[8'h80 + 8'(i)]}, 32'h5A);
    check("fill3_untouched", {24'd0, ram[8'h83]}, {24'd0, 8'h83 ^ 8'h5C});

    // 3: zero length
    run_req("copy0", 1'b0, 8'h20, 8'h30, 0, 8'h00);
    run_req("fill0", 1'b1, 8'h00, 8'h30, 0, 8'hEE);

    // 4: address wrap on source and destination
    preload(8'hFE, 8'h11); preload(8'hFF, 8'h22); preload(8'h00, 8'h33);
    run_req("copywrap", 1'b0, 8'hFE, 8'h01, 3, 8'h00);
    pin = '{8'h11, 8'h22, 8'h33, 8'h00};
    for (int i = 0; i < 3; i++) check("copywrap_pin", {24'd0, ram[8'h01 + 8'(i)]}, {24'd0, pin[i]});
    run_req("fillwrap", 1'b1, 8'h00, 8'hFD, 5, 8'hC7);

    // Overlapping forward copy replicates the first byte
    preload(8'h20, 8'h77);
    run_req("overlap", 1'b0, 8'h20, 8'h21, 4, 8'h00);
    for (int i = 0; i < 5; i++) check("overlap_pin", {24'd0, ram[8'h20 + 8'(i)]}, 32'h77);

    // 5: second start ignored, then reset during a write cycle
    build_model(1'b0, 8'h50, 8'h60, 8, 8'h00);
    pulse_start(1'b0, 8'h50, 8'h60, 8, 8'h00);
    repeat (2) @(posedge CLK);
    #2;
    start = 1'b1; op = 1'b1; dst_addr = 8'hC0; length = 9'd2; fill_value = 8'h99;
    @(posedge CLK); #1;
    start = 1'b0;
    lim = 0;
    while (!mif.MemWrite && lim < 50) begin
      @(posedge CLK); #1;
      lim++;
    end
    check("abort_reached_wr", {31'd0, mif.MemWrite}, 32'd1);
    #1;
    RESET_N = 1'b0;
    #1;
    check("abort_outputs_zero",
          {busy, done, bytes_done, mif.MemRead, mif.MemWrite, mif.mem_index, mif.write_value},
          32'd0);
    exp_q.delete();
    req_id++;
    repeat (2) @(posedge CLK);
    #2;
    RESET_N = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge CLK); #1;
      if (busy) check("abort_not_resumed", 32'd1, 32'd0);
    end
    check("abort_idle", {30'd0, busy, done}, 32'd0);
    check("abort_c0_untouched", {24'd0, ram[8'hC0]}, {24'd0, 8'hC0 ^ 8'h5C});
    for (int i = 0; i < 256; i++) exp_ram[i] = ram[i];

    run_req("recover", 1'b1, 8'h00, 8'hC0, 2, 8'h99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
